// File: rtl/dsp_div_32_16.sv
// rtl/dsp_div_32_16.sv - 32/16 signed restoring divider, fixed 34-cycle latency
//
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   start    request strobe; X and B are sampled when idle
//   X        signed 32-bit dividend
//   B        signed 16-bit divisor
//   busy     high while a division is in CALC or FIX
//   done     one-cycle strobe, Q/R/ovf/dbz update with it
//   Q        signed quotient, truncated toward zero, saturated on overflow
//   R        signed remainder, sign follows X
//   ovf      quotient did not fit in 16 bits
//   dbz      divide by zero

module dsp_div_32_16 (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] X,
    input  logic [15:0] B,
    output logic        busy,
    output logic        done,
    output logic [15:0] Q,
    output logic [15:0] R,
    output logic        ovf,
    output logic        dbz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [4:0]  cnt;
    logic [32:0] quo;        // dividend shifts out of the top, quotient bits enter at the bottom
    logic [16:0] rem;
    logic [16:0] mag_b;
    logic        x_neg;
    logic        b_neg;
    logic        b_zero;

    // Result stage between FIX and the outputs; this extra register is what
    // brings the start-to-done latency to 34 cycles.
    logic [15:0] res_q;
    logic [15:0] res_r;
    logic        res_ovf;
    logic        res_dbz;
    logic        res_vld;

    // Magnitudes are taken on 33/17 bits so that -2^31 and -32768 negate cleanly.
    logic [32:0] x_ext;
    logic [32:0] x_mag;
    logic [16:0] b_ext;
    logic [16:0] b_mag;

    assign x_ext = {X[31], X};
    assign x_mag = X[31] ? (33'd0 - x_ext) : x_ext;
    assign b_ext = {B[15], B};
    assign b_mag = B[15] ? (17'd0 - b_ext) : b_ext;

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    logic [17:0] shifted;
    logic        fits;
    logic [16:0] rem_nx;

    assign shifted = {rem, quo[31]};
    assign fits    = (shifted >= {1'b0, mag_b});
    assign rem_nx  = fits ? (shifted[16:0] - mag_b) : shifted[16:0];

    // Sign application and saturation, evaluated while in FIX.
    logic        q_neg;
    logic        q_over;
    logic [15:0] fix_q;
    logic [15:0] fix_r;
    logic        fix_ovf;
    logic        fix_dbz;

    assign q_neg  = x_neg ^ b_neg;
    // A negative quotient may reach magnitude 32768, a positive one only 32767.
    assign q_over = q_neg ? (quo > 33'd32768) : (quo > 33'd32767);

    always_comb begin
        fix_q   = 16'd0;
        fix_r   = 16'd0;
        fix_ovf = 1'b0;
        fix_dbz = 1'b0;
        if (b_zero) begin
            fix_dbz = 1'b1;
        end else if (q_over) begin
            fix_ovf = 1'b1;
            fix_q   = q_neg ? 16'h8000 : 16'h7FFF;
        end else begin
            fix_q = q_neg ? (16'd0 - quo[15:0]) : quo[15:0];
            fix_r = x_neg ? (16'd0 - rem[15:0]) : rem[15:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CALC;
            CALC:    if (cnt == 5'd31) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == CALC) || (state == FIX);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= 5'd0;
            quo     <= 33'd0;
            rem     <= 17'd0;
            mag_b   <= 17'd0;
            x_neg   <= 1'b0;
            b_neg   <= 1'b0;
            b_zero  <= 1'b0;
            res_q   <= 16'd0;
            res_r   <= 16'd0;
            res_ovf <= 1'b0;
            res_dbz <= 1'b0;
            res_vld <= 1'b0;
            done    <= 1'b0;
            Q       <= 16'd0;
            R       <= 16'd0;
            ovf     <= 1'b0;
            dbz     <= 1'b0;
        end else begin
            res_vld <= 1'b0;
            done    <= res_vld;
            if (res_vld) begin
                Q   <= res_q;
                R   <= res_r;
                ovf <= res_ovf;
                dbz <= res_dbz;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        quo    <= x_mag;
                        rem    <= 17'd0;
                        mag_b  <= b_mag;
                        x_neg  <= X[31];
                        b_neg  <= B[15];
                        b_zero <= (B == 16'd0);
                        cnt    <= 5'd0;
                    end
                end
                CALC: begin
                    rem <= rem_nx;
                    quo <= {1'b0, quo[30:0], fits};
                    cnt <= cnt + 5'd1;
                end
                FIX: begin
                    res_q   <= fix_q;
                    res_r   <= fix_r;
                    res_ovf <= fix_ovf;
                    res_dbz <= fix_dbz;
                    res_vld <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_div_32_16.sv
// tb/tb_dsp_div_32_16.sv - directed and product-inverse checks for dsp_div_32_16

module tb_dsp_div_32_16;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [31:0] X;
    logic [15:0] B;
    logic        busy;
    logic        done;
    logic [15:0] Q;
    logic [15:0] R;
    logic        ovf;
    logic        dbz;

    int checks = 0;
    int errors = 0;

    dsp_div_32_16 dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .X       (X),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .Q       (Q),
        .R       (R),
        .ovf     (ovf),
        .dbz     (dbz)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Wait for done after a start edge; returns cycles from the start edge (-1 on timeout).
    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [31:0] x, input logic [15:0] b, output int lat);
        @(negedge clock);
        X = x;
        B = b;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(lat);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        start = 1'b0;
        X = 32'd0;
        B = 16'd0;
        repeat (3) @(negedge clock);
        checks++;
        if ({busy, done, ovf, dbz, Q, R} !== 36'd0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b done=%b ovf=%b dbz=%b Q=%h R=%h required all 0",
                     busy, done, ovf, dbz, Q, R);
        end
    endtask

    task automatic test_basic;
        int lat;
        // reset release and start together: start must be accepted on the first edge
        @(negedge clock);
        reset_n = 1'b1;
        X = 32'h00000064;
        B = 16'h0007;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL first_start_busy got %b required 1", busy);
        end
        wait_done(lat);
        checks++;
        if (lat != 34) begin
            errors++;
            $display("FAIL basic_latency got %0d required 34", lat);
        end
        checks++;
        if (Q !== 16'h000E || R !== 16'h0002 || ovf !== 1'b0 || dbz !== 1'b0) begin
            errors++;
            $display("FAIL basic_result Q=%h R=%h ovf=%b dbz=%b required 000e 0002 0 0", Q, R, ovf, dbz);
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_one_cycle done=%b busy=%b required 0 0", done, busy);
        end
        repeat (3) @(negedge clock);
        checks++;
        if (Q !== 16'h000E || R !== 16'h0002) begin
            errors++;
            $display("FAIL result_hold Q=%h R=%h required 000e 0002", Q, R);
        end
    endtask

    task automatic test_negative;
        int lat;
        run_op(32'hFFFFFF9C, 16'h0007, lat);
        checks++;
        if (lat != 34 || Q !== 16'hFFF2 || R !== 16'hFFFE || ovf !== 1'b0 || dbz !== 1'b0) begin
            errors++;
            $display("FAIL neg_dividend lat=%0d Q=%h R=%h ovf=%b dbz=%b required 34 fff2 fffe 0 0",
                     lat, Q, R, ovf, dbz);
        end
        run_op(32'h00000064, 16'hFFF9, lat);
        checks++;
        if (Q !== 16'hFFF2 || R !== 16'h0002 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL neg_divisor Q=%h R=%h ovf=%b required fff2 0002 0", Q, R, ovf);
        end
    endtask

    task automatic test_overflow;
        int lat;
        logic [31:0] xv [5];
        logic [15:0] bv [5];
        logic [15:0] qv [5];
        logic        ov [5];
        xv[0] = 32'h40000000; bv[0] = 16'h8000; qv[0] = 16'h8000; ov[0] = 1'b0;
        xv[1] = 32'hC0000000; bv[1] = 16'h8000; qv[1] = 16'h7FFF; ov[1] = 1'b1;
        xv[2] = 32'h80000000; bv[2] = 16'hFFFF; qv[2] = 16'h7FFF; ov[2] = 1'b1;
        xv[3] = 32'hFFFF0000; bv[3] = 16'h0001; qv[3] = 16'h8000; ov[3] = 1'b1;
        xv[4] = 32'h00008000; bv[4] = 16'hFFFF; qv[4] = 16'h8000; ov[4] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            run_op(xv[i], bv[i], lat);
            checks++;
            if (lat != 34 || Q !== qv[i] || R !== 16'h0000 || ovf !== ov[i] || dbz !== 1'b0) begin
                errors++;
                $display("FAIL overflow_%0d lat=%0d Q=%h R=%h ovf=%b dbz=%b required 34 %h 0000 %b 0",
                         i, lat, Q, R, ovf, dbz, qv[i], ov[i]);
            end
        end
    endtask

    task automatic test_div_by_zero;
        int lat;
        run_op(32'h12345678, 16'h0000, lat);
        checks++;
        if (lat != 34 || Q !== 16'h0000 || R !== 16'h0000 || ovf !== 1'b0 || dbz !== 1'b1) begin
            errors++;
            $display("FAIL div_by_zero lat=%0d Q=%h R=%h ovf=%b dbz=%b required 34 0000 0000 0 1",
                     lat, Q, R, ovf, dbz);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        int extra;
        @(negedge clock);
        X = 32'h00000064;
        B = 16'h0007;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            if (c == 10) begin
                X = 32'h00001000;
                B = 16'h0002;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            if (done) begin
                lat = c;
                break;
            end
        end
        start = 1'b0;
        checks++;
        if (lat != 34 || Q !== 16'h000E || R !== 16'h0002) begin
            errors++;
            $display("FAIL busy_start_ignored lat=%0d Q=%h R=%h required 34 000e 0002", lat, Q, R);
        end
        // start during the done cycle
        X = 32'hFFFFFC18;
        B = 16'h0003;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL done_cycle_start_busy got %b required 1", busy);
        end
        wait_done(lat);
        checks++;
        if (lat != 34 || Q !== 16'hFEB3 || R !== 16'hFFFF || ovf !== 1'b0) begin
            errors++;
            $display("FAIL done_cycle_start lat=%0d Q=%h R=%h ovf=%b required 34 feb3 ffff 0", lat, Q, R, ovf);
        end
        extra = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (done) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL spurious_done got %0d required 0", extra);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        @(negedge clock);
        X = 32'h00001000;
        B = 16'h0010;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (19) @(negedge clock);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, ovf, dbz, Q, R} !== 36'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs busy=%b done=%b ovf=%b dbz=%b Q=%h R=%h required all 0",
                     busy, done, ovf, dbz, Q, R);
        end
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            if (done || busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_mid_abort active_cycles=%0d required 0", seen);
        end
    endtask

    task automatic test_product_inverse;
        int lat;
        logic signed [15:0] a;
        logic signed [15:0] b;
        logic signed [31:0] x;
        logic [15:0] ca [6];
        logic [15:0] cb [6];
        ca[0] = 16'h8000; cb[0] = 16'h8000;
        ca[1] = 16'h8000; cb[1] = 16'h0001;
        ca[2] = 16'h7FFF; cb[2] = 16'h8000;
        ca[3] = 16'h8000; cb[3] = 16'hFFFF;
        ca[4] = 16'h7FFF; cb[4] = 16'h7FFF;
        ca[5] = 16'h0000; cb[5] = 16'h0005;
        for (int i = 0; i < 1006; i++) begin
            if (i < 6) begin
                a = ca[i];
                b = cb[i];
            end else begin
                a = 16'($urandom);
                b = 16'($urandom);
                if (b == 16'sd0) b = 16'sd1;
            end
            x = a * b;
            run_op(x, b, lat);
            checks++;
            if (lat != 34 || Q !== a || R !== 16'h0000 || ovf !== 1'b0 || dbz !== 1'b0) begin
                errors++;
                $display("FAIL product_inverse a=%h b=%h lat=%0d Q=%h R=%h ovf=%b dbz=%b required Q=%h R=0000",
                         a, b, lat, Q, R, ovf, dbz, a);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_negative;
        test_overflow;
        test_div_by_zero;
        test_back_to_back;
        test_reset_mid;
        test_product_inverse;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
